// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle, non-pipelined instruction fetch and sequencing FSM.
// It fetches a 32-bit word from unified memory at pc and holds it in the instruction register.
// It presents the decoded fields to the execute/memory stage.
// It paces each instruction through FETCH, WAIT, DECODE, EXEC, optional MEM, and WB.
// The address bus is shared with LDR/STR data accesses. addr_sel_pc claims the bus
// only while an instruction word is being fetched.
// Instruction format: [31:28] op_code, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.

module fetch_sequencer #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int MEM_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [31:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic            addr_sel_pc,
    output logic            fetch_req,
    output logic [3:0]      op_code,
    output logic [3:0]      rd,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [15:0]     imm,
    output logic            exec_en,
    output logic            mem_phase,
    output logic            wb_en,
    output logic            busy,
    output logic [15:0]     retired
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6
    } state_t;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
    localparam logic [2:0]      LAT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [31:0]     IR_NOP     = 32'hF000_0000;

    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // ------------------------------------------------------------------
    // Opcode classification helpers
    // ------------------------------------------------------------------

    // LDR and STR are the only ops that take a data-memory cycle.
    function automatic logic is_mem_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_LDR:  res = 1'b1;
            OP_STR:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // CMP only sets flags. STR writes memory, not the register file. NOP does nothing.
    // All other ops, LDR included, write rd.
    function automatic logic writes_back(input logic [3:0] op);
        logic res;
        case (op)
            OP_CMP:  res = 1'b0;
            OP_STR:  res = 1'b0;
            OP_NOP:  res = 1'b0;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        lat_cnt_r;
    logic [31:0]       ir_r;
    logic [PC_W-1:0]   pc_r;
    logic [15:0]       retired_r;

    // Registered strobes and their next-cycle values
    logic              fetch_req_r, fetch_req_d_s;
    logic              addr_sel_pc_r, addr_sel_pc_d_s;
    logic              exec_en_r, exec_en_d_s;
    logic              mem_phase_r, mem_phase_d_s;
    logic              wb_en_r, wb_en_d_s;
    logic              busy_r, busy_d_s;

    // Datapath update enables
    logic              ir_load_s;
    logic              retire_s;

    assign ir_load_s = (state_r == S_WAIT) && (lat_cnt_r == 3'd0);
    assign retire_s  = (state_r == S_WB);

    // FSM state register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: run is only looked at on instruction boundaries (IDLE and WB).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_r == 3'd0) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_DECODE: begin
                state_next_s = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem_op(ir_r[31:28])) begin
                    state_next_s = S_MEM;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_MEM: begin
                state_next_s = S_WB;
            end
            S_WB: begin
                if (run) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so each strobe is registered and lines up with its state.
    always_comb begin
        fetch_req_d_s   = 1'b0;
        addr_sel_pc_d_s = 1'b0;
        exec_en_d_s     = 1'b0;
        mem_phase_d_s   = 1'b0;
        wb_en_d_s       = 1'b0;
        busy_d_s        = (state_next_s != S_IDLE);
        case (state_next_s)
            S_IDLE: begin
                busy_d_s = 1'b0;
            end
            S_FETCH: begin
                fetch_req_d_s   = 1'b1;
                addr_sel_pc_d_s = 1'b1;
            end
            S_WAIT: begin
                addr_sel_pc_d_s = 1'b1;
            end
            S_DECODE: begin
                addr_sel_pc_d_s = 1'b0;
            end
            S_EXEC: begin
                exec_en_d_s = 1'b1;
            end
            S_MEM: begin
                // The data address from memory control owns the bus here.
                mem_phase_d_s   = 1'b1;
                addr_sel_pc_d_s = 1'b0;
            end
            S_WB: begin
                // The IR was latched back in WAIT, so its opcode is valid when WB is entered.
                wb_en_d_s = writes_back(ir_r[31:28]);
            end
            default: begin
                busy_d_s = 1'b0;
            end
        endcase
    end

    // Output strobe registers; async reset clears every strobe in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req_r   <= 1'b0;
            addr_sel_pc_r <= 1'b0;
            exec_en_r     <= 1'b0;
            mem_phase_r   <= 1'b0;
            wb_en_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            fetch_req_r   <= fetch_req_d_s;
            addr_sel_pc_r <= addr_sel_pc_d_s;
            exec_en_r     <= exec_en_d_s;
            mem_phase_r   <= mem_phase_d_s;
            wb_en_r       <= wb_en_d_s;
            busy_r        <= busy_d_s;
        end
    end

    // Memory latency counter: loaded in FETCH and counted down to zero through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_r <= 3'd0;
        end else if (state_r == S_FETCH) begin
            lat_cnt_r <= LAT_INIT;
        end else if ((state_r == S_WAIT) && (lat_cnt_r != 3'd0)) begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // Instruction register: captures read data only on the last WAIT cycle, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= IR_NOP;
        end else if (ir_load_s) begin
            ir_r <= instr_in;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Program counter and retired count: both advance once per completed instruction and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_PC_V;
            retired_r <= 16'h0000;
        end else if (retire_s) begin
            pc_r      <= pc_r + PC_ONE;
            retired_r <= retired_r + 16'h0001;
        end else begin
            pc_r      <= pc_r;
            retired_r <= retired_r;
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign pc          = pc_r;
    assign retired     = retired_r;
    assign fetch_req   = fetch_req_r;
    assign addr_sel_pc = addr_sel_pc_r;
    assign exec_en     = exec_en_r;
    assign mem_phase   = mem_phase_r;
    assign wb_en       = wb_en_r;
    assign busy        = busy_r;

    assign op_code = ir_r[31:28];
    assign rd      = ir_r[27:24];
    assign rs1     = ir_r[23:20];
    assign rs2     = ir_r[19:16];
    assign imm     = ir_r[15:0];

endmodule
